// File: rtl/crc_master_pkg.sv
// rtl/crc_master_pkg.sv - CRC peripheral register map, CTRL bit indices and master FSM states
package crc_master_pkg;

  localparam logic [31:0] CRC_BASE_ADDR = 32'h4003_2000;
  localparam logic [31:0] CRC_GPOLY_OFS = 32'h4;
  localparam logic [31:0] CRC_CTRL_OFS  = 32'h8;

  localparam int CTRL_TCRC_BIT = 24;
  localparam int CTRL_WAS_BIT  = 25;
  localparam int CTRL_FXOR_BIT = 26;

  typedef enum logic [2:0] {
    IDLE,
    W_POLY,
    W_CTRLS,
    W_SEED,
    W_CTRL,
    DATA,
    RD,
    DONE
  } state_t;

endpackage

// File: rtl/crc_bus_master.sv
// rtl/crc_bus_master.sv - bus initiator that programs the CRC slave, streams data words and reads the checksum
module crc_bus_master
  import crc_master_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = CRC_BASE_ADDR,
  parameter logic [31:0] GPOLY_OFS = CRC_GPOLY_OFS,
  parameter logic [31:0] CTRL_OFS  = CRC_CTRL_OFS,
  parameter int          WAS_BIT   = CTRL_WAS_BIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_ctrl,
  input  logic [31:0] cfg_poly,
  input  logic [31:0] cfg_seed,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        Sel,
  output logic        RW,
  output logic [31:0] addr,
  output logic [31:0] data_wr,
  input  logic [31:0] data_rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [31:0] WAS_MASK = 32'h1 << WAS_BIT;

  state_t      state, state_nx;
  logic        last_pend, last_pend_nx;
  logic [31:0] poly_q, ctrl_q, seed_q;
  logic        sel_nx, rw_nx, busy_nx, done_nx;
  logic [31:0] addr_nx, wdata_nx;
  logic        hs;

  // last_pend blocks further handshakes while the final word's write is on the bus
  assign in_ready = (state == DATA) && !last_pend;
  assign hs       = in_valid && in_ready;

  // Each arm programs the bus cycle that the *next* state presents, so outputs stay registered
  always_comb begin
    state_nx     = state;
    last_pend_nx = last_pend;
    sel_nx       = 1'b0;
    rw_nx        = 1'b0;
    addr_nx      = 32'h0;
    wdata_nx     = 32'h0;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = W_POLY;
          sel_nx   = 1'b1;
          rw_nx    = 1'b1;
          addr_nx  = BASE_ADDR + GPOLY_OFS;
          wdata_nx = cfg_poly;
          busy_nx  = 1'b1;
        end
      end
      W_POLY: begin
        state_nx = W_CTRLS;
        sel_nx   = 1'b1;
        rw_nx    = 1'b1;
        addr_nx  = BASE_ADDR + CTRL_OFS;
        wdata_nx = ctrl_q | WAS_MASK;
        busy_nx  = 1'b1;
      end
      W_CTRLS: begin
        state_nx = W_SEED;
        sel_nx   = 1'b1;
        rw_nx    = 1'b1;
        addr_nx  = BASE_ADDR;
        wdata_nx = seed_q;
        busy_nx  = 1'b1;
      end
      W_SEED: begin
        state_nx = W_CTRL;
        sel_nx   = 1'b1;
        rw_nx    = 1'b1;
        addr_nx  = BASE_ADDR + CTRL_OFS;
        wdata_nx = ctrl_q & ~WAS_MASK;
        busy_nx  = 1'b1;
      end
      W_CTRL: begin
        state_nx     = DATA;
        last_pend_nx = 1'b0;
        busy_nx      = 1'b1;
      end
      DATA: begin
        busy_nx = 1'b1;
        if (last_pend) begin
          state_nx     = RD;
          last_pend_nx = 1'b0;
          sel_nx       = 1'b1;
          addr_nx      = BASE_ADDR;
        end else if (hs) begin
          sel_nx       = 1'b1;
          rw_nx        = 1'b1;
          addr_nx      = BASE_ADDR;
          wdata_nx     = in_data;
          last_pend_nx = in_last;
        end
      end
      RD: begin
        state_nx = DONE;
        done_nx  = 1'b1;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (abort && (state != IDLE)) begin
      state_nx     = IDLE;
      last_pend_nx = 1'b0;
      sel_nx       = 1'b0;
      rw_nx        = 1'b0;
      addr_nx      = 32'h0;
      wdata_nx     = 32'h0;
      busy_nx      = 1'b0;
      done_nx      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_pend <= 1'b0;
      Sel       <= 1'b0;
      RW        <= 1'b0;
      addr      <= 32'h0;
      data_wr   <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 32'h0;
      poly_q    <= 32'h0;
      ctrl_q    <= 32'h0;
      seed_q    <= 32'h0;
    end else begin
      state     <= state_nx;
      last_pend <= last_pend_nx;
      Sel       <= sel_nx;
      RW        <= rw_nx;
      addr      <= addr_nx;
      data_wr   <= wdata_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      if ((state == IDLE) && start) begin
        poly_q <= cfg_poly;
        ctrl_q <= cfg_ctrl;
        seed_q <= cfg_seed;
      end
      if ((state == RD) && !abort) begin
        result <= data_rd;
      end
    end
  end

endmodule

// File: tb/tb_crc_bus_master.sv
// tb/tb_crc_bus_master.sv - directed self-checking bench for crc_bus_master with a CRC slave model
module tb_crc_bus_master;

  localparam logic [31:0] BASE = 32'h4003_2000;
  localparam logic [31:0] WAS  = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid, in_last;
  logic [31:0] cfg_ctrl, cfg_poly, cfg_seed, in_data;
  logic        in_ready, Sel, RW, busy, done;
  logic [31:0] addr, data_wr, data_rd, result;

  int n_checks = 0;
  int n_fail   = 0;

  crc_bus_master dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_ctrl(cfg_ctrl), .cfg_poly(cfg_poly), .cfg_seed(cfg_seed),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .Sel(Sel), .RW(RW), .addr(addr), .data_wr(data_wr), .data_rd(data_rd),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // CRC slave: non-transposed 32-bit CRC, MSB first, WAS selects seed load
  logic [31:0] s_crc = 32'h0, s_poly = 32'h0, s_ctrl = 32'h0, rd_const = 32'h0;
  bit          use_crc = 1'b0;
  int          n_wr = 0;

  function automatic logic [31:0] crc_shift(input logic [31:0] c, input logic [31:0] d, input logic [31:0] p);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ p;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (Sel && RW) begin
      n_wr <= n_wr + 1;
      if (addr == BASE)              s_crc  <= s_ctrl[25] ? data_wr : crc_shift(s_crc, data_wr, s_poly);
      else if (addr == BASE + 32'h4) s_poly <= data_wr;
      else if (addr == BASE + 32'h8) s_ctrl <= data_wr;
    end
  end

  assign data_rd = (Sel && !RW && addr == BASE) ? (use_crc ? s_crc : rd_const) : 32'h0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    check(tag, {Sel, RW, addr, data_wr}, {1'b1, 1'b1, a, d});
  endtask

  task automatic exp_idle(input string tag);
    check(tag, {Sel, RW, addr, data_wr}, {1'b0, 1'b0, 32'h0, 32'h0});
  endtask

  // Start a sequence, check the four programming writes, and stop in the first DATA cycle
  task automatic run_cfg(input string tag, input logic [31:0] p, input logic [31:0] c,
                         input logic [31:0] s, input bit with_abort, input bit restart);
    cfg_poly = p; cfg_ctrl = c; cfg_seed = s;
    start = 1'b1; abort = with_abort;
    tick();
    start = restart; abort = 1'b0;
    cfg_poly = ~p; cfg_ctrl = ~c; cfg_seed = ~s;
    exp_wr({tag, " poly"}, BASE + 32'h4, p);
    check({tag, " busy"}, busy, 1'b1);
    check({tag, " ready_lo"}, in_ready, 1'b0);
    tick();
    start = 1'b0;
    exp_wr({tag, " ctrl_was"}, BASE + 32'h8, c | WAS);
    tick();
    exp_wr({tag, " seed"}, BASE, s);
    tick();
    exp_wr({tag, " ctrl"}, BASE + 32'h8, c & ~WAS);
    tick();
    exp_idle({tag, " data_idle"});
    check({tag, " ready_hi"}, in_ready, 1'b1);
  endtask

  // After the last word's write is visible: read cycle, then done pulse
  task automatic finish_msg(input string tag, input logic [31:0] exp_res);
    in_valid = 1'b0; in_data = 32'hBAD0_BAD0; in_last = 1'b0;
    check({tag, " last_ready_lo"}, in_ready, 1'b0);
    tick();
    check({tag, " read"}, {Sel, RW, addr}, {1'b1, 1'b0, BASE});
    check({tag, " no_done_rd"}, done, 1'b0);
    tick();
    check({tag, " done"}, {done, busy, Sel}, {1'b1, 1'b0, 1'b0});
    check({tag, " result"}, result, exp_res);
    tick();
    check({tag, " done_cleared"}, {done, busy}, {1'b0, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base_wr;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
    cfg_ctrl = 32'h0; cfg_poly = 32'h0; cfg_seed = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset ctl", {Sel, RW, in_ready, busy, done}, 5'b0);
    check("reset data", {addr, data_wr, result}, 96'h0);

    // Basic single-word sequence
    rd_const = 32'hDEAD_BEEF;
    run_cfg("basic", 32'h0000_1021, 32'h0100_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 32'h1234_5678; in_last = 1'b1;
    tick();
    exp_wr("basic word", BASE, 32'h1234_5678);
    finish_msg("basic", 32'hDEAD_BEEF);

    // Four back-to-back words
    rd_const = 32'hCAFE_0001;
    run_cfg("b2b", 32'h0000_8005, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'hA000_0000 + i; in_last = (i == 3);
      tick();
      exp_wr($sformatf("b2b w%0d", i), BASE, 32'hA000_0000 + i);
    end
    finish_msg("b2b", 32'hCAFE_0001);

    // in_valid toggling: gaps on the bus where no handshake happened
    rd_const = 32'h5A5A_A5A5;
    run_cfg("tog", 32'h1111_2222, 32'h0100_0000, 32'h3333_4444, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hB000_0010 + i; in_last = (i == 2);
      tick();
      exp_wr($sformatf("tog w%0d", i), BASE, 32'hB000_0010 + i);
      if (i < 2) begin
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        exp_idle($sformatf("tog gap%0d", i));
      end
    end
    finish_msg("tog", 32'h5A5A_A5A5);

    // Abort after the second data write, with a third handshake offered
    rd_const = 32'h7777_7777;
    run_cfg("abort", 32'h0000_1021, 32'h0100_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 32'hC000_0000; in_last = 1'b0;
    tick();
    exp_wr("abort w0", BASE, 32'hC000_0000);
    in_data = 32'hC000_0001;
    tick();
    exp_wr("abort w1", BASE, 32'hC000_0001);
    in_data = 32'hC000_0002; abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    exp_idle("abort idle");
    check("abort flags", {busy, done, in_ready}, 3'b0);
    tick();
    check("abort no_done", {done, Sel, busy}, 3'b0);
    check("abort result kept", result, 32'h5A5A_A5A5);

    // Async reset in W_SEED, then a full rerun
    cfg_poly = 32'h0000_1021; cfg_ctrl = 32'h0100_0000; cfg_seed = 32'hFFFF_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    exp_wr("rst pre seed", BASE, 32'hFFFF_FFFF);
    #2 rst = 1'b1;
    #1;
    check("rst async", {Sel, RW, busy}, 3'b0);
    tick();
    rst = 1'b0;
    tick();
    check("rst result", result, 32'h0);
    exp_idle("rst idle");
    rd_const = 32'h1357_9BDF;
    run_cfg("rerun", 32'h0000_1021, 32'h0100_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 32'h0BAD_F00D; in_last = 1'b1;
    tick();
    exp_wr("rerun word", BASE, 32'h0BAD_F00D);
    finish_msg("rerun", 32'h1357_9BDF);

    // start pulsed while busy must not spawn a second sequence
    base_wr = n_wr;
    rd_const = 32'hDEAD_BEEF;
    run_cfg("sbusy", 32'h0000_1021, 32'h0100_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    start = 1'b1;
    in_valid = 1'b1; in_data = 32'h1234_5678; in_last = 1'b1;
    tick();
    start = 1'b0;
    exp_wr("sbusy word", BASE, 32'h1234_5678);
    finish_msg("sbusy", 32'hDEAD_BEEF);
    tick(); tick();
    exp_idle("sbusy after");
    check("sbusy busy", busy, 1'b0);
    check("sbusy writes", n_wr - base_wr, 5);

    // Integration with the slave CRC model; start and abort together in IDLE
    use_crc = 1'b1;
    run_cfg("crc", 32'h04C1_1DB7, 32'h0100_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 32'h0000_0000; in_last = 1'b1;
    tick();
    exp_wr("crc word", BASE, 32'h0000_0000);
    finish_msg("crc", 32'hC704_DD7B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
